// File: rtl/regfile_write_arb.sv
// regfile_write_arb: round-robin arbiter sharing the architectural register file write port
// among NUM_REQ producers, with one registered output stage and read-side forwarding.
// Optional feature macro: ZERO_REG_DROP_EN -- granted writes to register 31 are consumed
// but never presented to the register file and never forwarded.
module regfile_write_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      wr_stall_i,
    output logic                      RegWrite_o,
    output logic [ADDR_W-1:0]         WriteRegister_o,
    output logic [DATA_W-1:0]         WriteData_o,
    input  logic [ADDR_W-1:0]         fwd_addr_i,
    output logic                      fwd_hit_o,
    output logic [DATA_W-1:0]         fwd_data_o,
    output logic [CNT_W-1:0]          grant_cnt_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
`ifdef ZERO_REG_DROP_EN
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);
`endif

    // Per-requester views of the flattened address/data buses
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    // State: output stage, round-robin pointer, grant counter
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Arbitration results
    logic [NUM_REQ-1:0] grant_c;
    logic [PTR_W-1:0]   win_idx_c;
    logic               found_c;
    logic               xfer_c;
    logic [SUM_W-1:0]   probe_c;
    logic [PTR_W-1:0]   probe_idx_c;
    logic [ADDR_W-1:0]  win_addr_c;
    logic [DATA_W-1:0]  win_data_c;
    logic               fwd_hit_c;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
            assign data_arr[g] = req_data_i[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search: first valid index at or after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        grant_c     = '0;
        win_idx_c   = '0;
        found_c     = 1'b0;
        probe_c     = '0;
        probe_idx_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            probe_c = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (probe_c >= NUM_REQ_S) begin
                probe_c = probe_c - NUM_REQ_S;
            end
            probe_idx_c = probe_c[PTR_W-1:0];
            if (!found_c && req_valid_i[probe_idx_c]) begin
                found_c   = 1'b1;
                win_idx_c = probe_idx_c;
            end
        end
        xfer_c = reset && !wr_stall_i && found_c;
        if (xfer_c) begin
            grant_c[win_idx_c] = 1'b1;
        end
    end

    assign win_addr_c = addr_arr[win_idx_c];
    assign win_data_c = data_arr[win_idx_c];

    // Next-state for output stage, pointer and counter on a completed handshake
    always_comb begin
        regwrite_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        if (xfer_c) begin
            rr_ptr_d = (win_idx_c == LAST_IDX) ? '0 : win_idx_c + PTR_W'(1);
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef ZERO_REG_DROP_EN
            if (win_addr_c != ZERO_REG) begin
                regwrite_d = 1'b1;
                waddr_d    = win_addr_c;
                wdata_d    = win_data_c;
            end
`else
            regwrite_d = 1'b1;
            waddr_d    = win_addr_c;
            wdata_d    = win_data_c;
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Forward the staged write to a same-cycle reader
    always_comb begin
`ifdef ZERO_REG_DROP_EN
        fwd_hit_c = regwrite_q && (waddr_q == fwd_addr_i) && (waddr_q != ZERO_REG);
`else
        fwd_hit_c = regwrite_q && (waddr_q == fwd_addr_i);
`endif
        fwd_data_o = fwd_hit_c ? wdata_q : '0;
    end

    assign fwd_hit_o       = fwd_hit_c;
    assign req_ready_o     = grant_c;
    assign RegWrite_o      = regwrite_q;
    assign WriteRegister_o = waddr_q;
    assign WriteData_o     = wdata_q;
    assign grant_cnt_o     = cnt_q;

endmodule

// File: tb/tb_regfile_write_arb.sv
// Self-checking bench for regfile_write_arb: vector table, directed corner sequences and
// randomized traffic against a queue-free behavioural model of the arbiter and write stage.
module tb_regfile_write_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SAT_W   = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        valid;
    logic                      stall;
    logic [ADDR_W-1:0]         fwd_addr;
    logic [ADDR_W-1:0]         addr [NUM_REQ];
    logic [DATA_W-1:0]         data [NUM_REQ];
    logic [NUM_REQ*ADDR_W-1:0] addr_flat;
    logic [NUM_REQ*DATA_W-1:0] data_flat;

    logic [NUM_REQ-1:0] ready, ready2;
    logic               rw, rw2, hit, hit2;
    logic [ADDR_W-1:0]  wreg, wreg2;
    logic [DATA_W-1:0]  wdata, wdata2, fdata, fdata2;
    logic [CNT_W-1:0]   cnt;
    logic [SAT_W-1:0]   cnt2;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_flat[k*ADDR_W +: ADDR_W] = addr[k];
            data_flat[k*DATA_W +: DATA_W] = data[k];
        end
    end

    regfile_write_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rst_n), .req_valid_i(valid), .req_addr_i(addr_flat),
        .req_data_i(data_flat), .req_ready_o(ready), .wr_stall_i(stall), .RegWrite_o(rw),
        .WriteRegister_o(wreg), .WriteData_o(wdata), .fwd_addr_i(fwd_addr), .fwd_hit_o(hit),
        .fwd_data_o(fdata), .grant_cnt_o(cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    regfile_write_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(rst_n), .req_valid_i(valid), .req_addr_i(addr_flat),
        .req_data_i(data_flat), .req_ready_o(ready2), .wr_stall_i(stall), .RegWrite_o(rw2),
        .WriteRegister_o(wreg2), .WriteData_o(wdata2), .fwd_addr_i(fwd_addr), .fwd_hit_o(hit2),
        .fwd_data_o(fdata2), .grant_cnt_o(cnt2)
    );

    // Reference model state
    int                 m_ptr;
    logic               m_rw;
    logic [ADDR_W-1:0]  m_waddr;
    logic [DATA_W-1:0]  m_wdata;
    int                 m_cnt;
    int                 m_cnt3;
    bit                 model_valid;
    logic [NUM_REQ-1:0] obs_ready;
    logic [DATA_W-1:0]  dut_rf [32];
    int                 checks;
    int                 errors;

    typedef struct {
        logic               rst_n;
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_rw;
        logic [CNT_W-1:0]   exp_cnt;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit dropped(input logic [ADDR_W-1:0] a);
`ifdef ZERO_REG_DROP_EN
        return a == ADDR_W'(31);
`else
        return a == ADDR_W'(31) && 1'b0;
`endif
    endfunction

    // One clock: check combinational outputs, advance model at the edge, check registers
    task automatic cycle();
        int   w;
        int   k;
        bit   found;
        logic hit_e;
        logic [NUM_REQ-1:0] exp_ready;
        w = 0;
        found = 1'b0;
        #1;
        if (rst_n && !stall) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                k = (m_ptr + i) % NUM_REQ;
                if (!found && valid[k]) begin
                    found = 1'b1;
                    w = k;
                end
            end
        end
        exp_ready = '0;
        if (found) exp_ready[w] = 1'b1;
        obs_ready = ready;
        check("req_ready", 64'(ready), 64'(exp_ready));
        if (model_valid) begin
            hit_e = m_rw && (m_waddr == fwd_addr) && !dropped(m_waddr);
            check("fwd_hit", 64'(hit), 64'(hit_e));
            check("fwd_data", fdata, hit_e ? m_wdata : 64'd0);
        end
        if (rw === 1'b1) dut_rf[wreg] = wdata;
        @(posedge clk);
        if (!rst_n) begin
            m_rw = 1'b0; m_waddr = '0; m_wdata = '0;
            m_cnt = 0; m_cnt3 = 0; m_ptr = 0;
            model_valid = 1'b1;
        end else if (found) begin
            m_ptr  = (w + 1) % NUM_REQ;
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : m_cnt3;
            if (dropped(addr[w])) begin
                m_rw = 1'b0;
            end else begin
                m_rw = 1'b1; m_waddr = addr[w]; m_wdata = data[w];
            end
        end else begin
            m_rw = 1'b0;
        end
        #1;
        if (model_valid) begin
            check("RegWrite", 64'(rw), 64'(m_rw));
            check("WriteRegister", 64'(wreg), 64'(m_waddr));
            check("WriteData", wdata, m_wdata);
            check("grant_cnt", 64'(cnt), 64'(m_cnt));
            check("grant_cnt_sat", 64'(cnt2), 64'(m_cnt3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; model_valid = 1'b0;
        m_ptr = 0; m_rw = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_cnt3 = 0;
        for (int r = 0; r < 32; r++) dut_rf[r] = '0;
        rst_n = 1'b0; valid = '0; stall = 1'b0; fwd_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            addr[k] = ADDR_W'(k + 10);
            data[k] = 64'h1000 + 64'(k);
        end

        // Reset with all requesting, then 8 round-robin grants
        vecs[0] = '{1'b0, 4'hF, 4'h0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 4'hF, 4'h0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 4'hF, 4'h1, 1'b1, 16'd1};
        vecs[3] = '{1'b1, 4'hF, 4'h2, 1'b1, 16'd2};
        vecs[4] = '{1'b1, 4'hF, 4'h4, 1'b1, 16'd3};
        vecs[5] = '{1'b1, 4'hF, 4'h8, 1'b1, 16'd4};
        vecs[6] = '{1'b1, 4'hF, 4'h1, 1'b1, 16'd5};
        vecs[7] = '{1'b1, 4'hF, 4'h2, 1'b1, 16'd6};
        vecs[8] = '{1'b1, 4'hF, 4'h4, 1'b1, 16'd7};
        vecs[9] = '{1'b1, 4'hF, 4'h8, 1'b1, 16'd8};
        @(posedge clk); #1;
        for (int v = 0; v < 10; v++) begin
            rst_n = vecs[v].rst_n;
            valid = vecs[v].valid;
            cycle();
            check("vec_ready", 64'(obs_ready), 64'(vecs[v].exp_ready));
            check("vec_RegWrite", 64'(rw), 64'(vecs[v].exp_rw));
            check("vec_grant_cnt", 64'(cnt), 64'(vecs[v].exp_cnt));
        end

        // Forwarding of a fresh write to X5
        valid = 4'h1; addr[0] = 5'd5; data[0] = 64'hA5A5_0000_0000_0001;
        cycle();
        valid = 4'h0; fwd_addr = 5'd5; #1;
        check("fwd5_hit", 64'(hit), 64'd1);
        check("fwd5_data", fdata, 64'hA5A5_0000_0000_0001);
        fwd_addr = 5'd6; #1;
        check("fwd6_hit", 64'(hit), 64'd0);
        check("fwd6_data", fdata, 64'd0);
        cycle();

        // Same-address contention on X7 starting from rr_ptr=1
        valid = 4'h6; addr[1] = 5'd7; data[1] = 64'd1; addr[2] = 5'd7; data[2] = 64'd2;
        cycle();
        check("x7_first", wdata, 64'd1);
        valid = 4'h4;
        cycle();
        check("x7_second", wdata, 64'd2);
        valid = 4'h0;
        cycle();
        cycle();
        check("x7_regfile", dut_rf[7], 64'd2);

        // Write to X31
        valid = 4'h8; addr[3] = 5'd31; data[3] = 64'hFF;
        cycle();
        check("x31_ready", 64'(obs_ready), 64'h8);
`ifdef ZERO_REG_DROP_EN
        check("x31_RegWrite", 64'(rw), 64'd0);
`else
        check("x31_RegWrite", 64'(rw), 64'd1);
        check("x31_WriteRegister", 64'(wreg), 64'd31);
`endif
        valid = 4'h0; fwd_addr = 5'd31; #1;
`ifdef ZERO_REG_DROP_EN
        check("x31_fwd_hit", 64'(hit), 64'd0);
`else
        check("x31_fwd_hit", 64'(hit), 64'd1);
`endif
        cycle();

        // Stall with a staged write in flight
        valid = 4'h1; addr[0] = 5'd9; data[0] = 64'h66;
        cycle();
        valid = 4'h2; stall = 1'b1; #1;
        check("stall_staged", 64'(rw), 64'd1);
        for (int s = 0; s < 3; s++) begin
            cycle();
            check("stall_ready", 64'(obs_ready), 64'd0);
            check("stall_RegWrite", 64'(rw), 64'd0);
        end
        stall = 1'b0;
        cycle();
        check("unstall_ready", 64'(obs_ready), 64'h2);
        valid = 4'h0;
        cycle();

        // Randomized traffic with stalls, resets and forwarding probes
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (valid[k] && obs_ready[k]) valid[k] = 1'b0;
                if (!valid[k] && ($urandom % 3 == 0)) begin
                    valid[k] = 1'b1;
                    addr[k]  = ADDR_W'($urandom_range(0, 31));
                    data[k]  = {$urandom, $urandom};
                end
            end
            stall    = ($urandom % 5 == 0);
            rst_n    = ($urandom % 50 != 0);
            fwd_addr = ($urandom % 2 == 0) ? m_waddr : ADDR_W'($urandom_range(0, 31));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
